// File: rtl/apb_chk_pkg.sv
// Shared types for the passive APB protocol checker: FSM states, error codes
// and the sticky-bit layout (bit n-1 holds error code n).
package apb_chk_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2
    } apb_state_e;

    typedef enum logic [2:0] {
        ERR_NONE            = 3'd0,
        ERR_ENABLE_NO_SETUP = 3'd1,
        ERR_NO_ENABLE       = 3'd2,
        ERR_UNSTABLE        = 3'd3,
        ERR_MULTI_SEL       = 3'd4,
        ERR_RD_STRB         = 3'd5,
        ERR_TIMEOUT         = 3'd6
    } apb_err_e;

    localparam int NUM_ERR = 6;

    localparam int STK_ENABLE_NO_SETUP = 0;
    localparam int STK_NO_ENABLE       = 1;
    localparam int STK_UNSTABLE        = 2;
    localparam int STK_MULTI_SEL       = 3;
    localparam int STK_RD_STRB         = 4;
    localparam int STK_TIMEOUT         = 5;

    // Lowest-numbered flagged code wins when several fire together.
    function automatic apb_err_e lowest_code(input logic [NUM_ERR-1:0] flags);
        if (flags[STK_ENABLE_NO_SETUP]) return ERR_ENABLE_NO_SETUP;
        if (flags[STK_NO_ENABLE])       return ERR_NO_ENABLE;
        if (flags[STK_UNSTABLE])        return ERR_UNSTABLE;
        if (flags[STK_MULTI_SEL])       return ERR_MULTI_SEL;
        if (flags[STK_RD_STRB])         return ERR_RD_STRB;
        if (flags[STK_TIMEOUT])         return ERR_TIMEOUT;
        return ERR_NONE;
    endfunction

endpackage

// File: rtl/apb_sat_cnt.sv
// Saturating up-counter with synchronous clear; an increment in the clear
// cycle lands on top of the cleared value.
module apb_sat_cnt #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] cnt
);

    localparam logic [W-1:0] ONE = W'(1);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr)
            cnt_d = '0;
        if (inc && (cnt_d != '1))
            cnt_d = cnt_d + ONE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/apb_protocol_checker.sv
// Passive APB monitor: tracks IDLE/SETUP/ACCESS from the bus pins and reports
// protocol violations as registered one-cycle pulses plus sticky/count status.
module apb_protocol_checker
    import apb_chk_pkg::*;
#(
    parameter int ADDR_W  = 12,
    parameter int DATA_W  = 32,
    parameter int NSEL    = 1,
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 16
) (
    input  logic                  clk,
    input  logic                  preset,
    input  logic [NSEL-1:0]       psel,
    input  logic                  penable,
    input  logic                  pwrite,
    input  logic [ADDR_W-1:0]     paddr,
    input  logic [DATA_W/8-1:0]   pstrb,
    input  logic [DATA_W-1:0]     pwdata,
    input  logic                  pready,
    input  logic                  pslverr,
    input  logic                  err_clr,
    output logic                  err_valid,
    output logic [2:0]            err_code,
    output logic [ADDR_W-1:0]     err_addr,
    output logic [NUM_ERR-1:0]    err_sticky,
    output logic [CNT_W-1:0]      err_count,
    output logic [CNT_W-1:0]      xfer_count,
    output logic [CNT_W-1:0]      slverr_count,
    output logic                  busy
);

    localparam int STRB_W = DATA_W / 8;
    localparam int WAIT_W = $clog2(TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(TIMEOUT);
    localparam logic [WAIT_W-1:0] WAIT_ONE = WAIT_W'(1);
    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);

    apb_state_e           state_q, state_d;
    logic [NSEL-1:0]      sel_q, sel_d;
    logic                 wr_q, wr_d;
    logic [ADDR_W-1:0]    addr_q, addr_d;
    logic [STRB_W-1:0]    strb_q, strb_d;
    logic [DATA_W-1:0]    wdata_q, wdata_d;
    logic [WAIT_W-1:0]    wait_q, wait_d;
    logic                 unst_q, unst_d;

    logic                 err_valid_q;
    logic [2:0]           err_code_q;
    logic [ADDR_W-1:0]    err_addr_q;
    logic [NUM_ERR-1:0]   sticky_q;
    logic [CNT_W-1:0]     xfer_q;

    logic [NUM_ERR-1:0]   flags;
    logic                 err_any;
    logic                 multi_sel;
    logic                 fields_changed;
    logic                 xfer_inc;
    logic                 slverr_inc;

    assign multi_sel      = ($countones(psel) > 1);
    assign fields_changed = (psel != sel_q) || (pwrite != wr_q) || (paddr != addr_q) ||
                            (pstrb != strb_q) || (pwdata != wdata_q);
    assign err_any        = |flags;

    always_comb begin
        state_d    = state_q;
        sel_d      = sel_q;
        wr_d       = wr_q;
        addr_d     = addr_q;
        strb_d     = strb_q;
        wdata_d    = wdata_q;
        wait_d     = wait_q;
        unst_d     = unst_q;
        flags      = '0;
        xfer_inc   = 1'b0;
        slverr_inc = 1'b0;

        flags[STK_MULTI_SEL] = multi_sel;

        case (state_q)
            ST_IDLE: begin
                if (penable) begin
                    flags[STK_ENABLE_NO_SETUP] = 1'b1;
                end else if (|psel) begin
                    state_d = ST_SETUP;
                    sel_d   = psel;
                    wr_d    = pwrite;
                    addr_d  = paddr;
                    strb_d  = pstrb;
                    wdata_d = pwdata;
                    if (!pwrite && (|pstrb))
                        flags[STK_RD_STRB] = 1'b1;
                end
            end
            ST_SETUP: begin
                if (penable && (psel == sel_q)) begin
                    state_d = ST_ACCESS;
                    wait_d  = '0;
                    unst_d  = 1'b0;
                end else begin
                    flags[STK_NO_ENABLE] = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            ST_ACCESS: begin
                if (pready) begin
                    xfer_inc   = 1'b1;
                    slverr_inc = pslverr;
                    state_d    = ST_IDLE;
                end else if (!penable || ((psel & sel_q) == '0)) begin
                    flags[STK_NO_ENABLE] = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    // Unstable is reported once per transfer; the wait counter
                    // parks at TIMEOUT so the timeout also fires only once.
                    if (fields_changed && !unst_q) begin
                        flags[STK_UNSTABLE] = 1'b1;
                        unst_d = 1'b1;
                    end
                    if (wait_q != WAIT_MAX) begin
                        wait_d = wait_q + WAIT_ONE;
                        if (wait_d == WAIT_MAX)
                            flags[STK_TIMEOUT] = 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge preset) begin
        if (preset) begin
            state_q <= ST_IDLE;
            sel_q   <= '0;
            wr_q    <= 1'b0;
            addr_q  <= '0;
            strb_q  <= '0;
            wdata_q <= '0;
            wait_q  <= '0;
            unst_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            wr_q    <= wr_d;
            addr_q  <= addr_d;
            strb_q  <= strb_d;
            wdata_q <= wdata_d;
            wait_q  <= wait_d;
            unst_q  <= unst_d;
        end
    end

    // In IDLE the offending address is still on the bus, not in the capture.
    always_ff @(posedge clk or posedge preset) begin
        if (preset) begin
            err_valid_q <= 1'b0;
            err_code_q  <= '0;
            err_addr_q  <= '0;
            sticky_q    <= '0;
            xfer_q      <= '0;
        end else begin
            err_valid_q <= err_any;
            if (err_any) begin
                err_code_q <= lowest_code(flags);
                err_addr_q <= (state_q == ST_IDLE) ? paddr : addr_q;
            end
            sticky_q <= (err_clr ? '0 : sticky_q) | flags;
            if (xfer_inc)
                xfer_q <= xfer_q + CNT_ONE;
        end
    end

    apb_sat_cnt #(.W(CNT_W)) u_err_cnt (
        .clk (clk),
        .rst (preset),
        .inc (err_any),
        .clr (err_clr),
        .cnt (err_count)
    );

    apb_sat_cnt #(.W(CNT_W)) u_slverr_cnt (
        .clk (clk),
        .rst (preset),
        .inc (slverr_inc),
        .clr (1'b0),
        .cnt (slverr_count)
    );

    assign err_valid  = err_valid_q;
    assign err_code   = err_code_q;
    assign err_addr   = err_addr_q;
    assign err_sticky = sticky_q;
    assign xfer_count = xfer_q;
    assign busy       = (state_q != ST_IDLE);

endmodule

// File: doc/apb_protocol_checker.md
APB_PROTOCOL_CHECKER -- requirements
Module: apb_protocol_checker

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 12, paddr width.
REQ-002 The block SHALL have parameter DATA_W, default 32, pwdata width; pstrb width is DATA_W/8.
REQ-003 The block SHALL have parameter NSEL, default 1, number of psel lines.
REQ-004 The block SHALL have parameter TIMEOUT, default 16, maximum wait-state cycles in ACCESS.
REQ-005 The block SHALL have parameter CNT_W, default 16, counter width.
REQ-006 The block SHALL have one clock and an asynchronous active-high reset, as ports clk (in, 1, rising-edge clock) and preset (in, 1, asynchronous active-high reset).
REQ-007 The block SHALL have passive APB inputs: psel (NSEL), penable (1), pwrite (1), paddr (ADDR_W), pstrb (DATA_W/8), pwdata (DATA_W), pready (1), pslverr (1).
REQ-008 The block SHALL have input err_clr (1), which clears sticky status and the error count.
REQ-009 The block SHALL have outputs err_valid (1, one-cycle error pulse), err_code (3), err_addr (ADDR_W, address of the offending transfer), err_sticky (6, one bit per code), err_count (CNT_W), xfer_count (CNT_W), slverr_count (CNT_W) and busy (1, state is not IDLE).

Function
REQ-010 The FSM SHALL have the states IDLE, SETUP and ACCESS, and SHALL sample all inputs on every rising clk edge.
REQ-011 In IDLE, any psel bit set with penable=0 SHALL move the FSM to SETUP and capture psel, pwrite, paddr, pstrb and pwdata.
REQ-012 In IDLE, penable=1 SHALL flag code 1 (ENABLE_NO_SETUP), and the FSM SHALL stay in IDLE.
REQ-013 In SETUP, psel unchanged with penable=1 SHALL move the FSM to ACCESS and clear the wait counter; any other input SHALL flag code 2 (NO_ENABLE) and return the FSM to IDLE.
REQ-014 In ACCESS with pready=1, the transfer SHALL complete: xfer_count increments (wrapping), slverr_count increments if pslverr=1 (saturating), and the FSM moves to IDLE, so a back-to-back SETUP is recognised on the next edge.
REQ-015 In ACCESS with pready=0, a drop of psel or penable SHALL flag code 2 and move the FSM to IDLE.
REQ-016 In ACCESS with pready=0, any captured field differing from its input SHALL flag code 3 (UNSTABLE) once per transfer, and the FSM SHALL stay in ACCESS.
REQ-017 More than one psel bit set in any state SHALL flag code 4 (MULTI_SEL).
REQ-018 A SETUP entry with pwrite=0 and pstrb nonzero SHALL flag code 5 (RD_STRB).
REQ-019 The wait counter SHALL increment on each ACCESS cycle with pready=0; reaching TIMEOUT SHALL flag code 6 (TIMEOUT) exactly once, and the FSM SHALL stay in ACCESS.
REQ-020 Errors SHALL be reported one cycle after the violating sample: err_valid=1 for one cycle, err_code set to the lowest simultaneous code, and err_addr set to the captured paddr (the live paddr for code 1).
REQ-021 All simultaneous codes SHALL set their err_sticky bits, and each error cycle SHALL increment err_count by one, saturating at all-ones.
REQ-022 err_clr SHALL zero err_sticky and err_count; an error in the same cycle SHALL win, leaving its sticky bit set and err_count=1.
REQ-023 Outputs other than err_valid SHALL hold their values between events.

Reset
REQ-024 preset=1 SHALL force IDLE asynchronously and zero every output, counter and capture register.
REQ-025 A reset mid-transfer SHALL abandon the transfer without flagging an error; the first post-reset cycle SHALL be evaluated from IDLE.

Structure
REQ-026 The package apb_chk_pkg SHALL hold the state enum, the 3-bit error-code enum (0 = none, 1-6) and the sticky-bit index constants.
REQ-027 A sub-module apb_sat_cnt (parameter W, inc, clr, saturating) SHALL implement err_count and slverr_count.

Verification
REQ-028 Bench SHALL drive a write to 0x010 with one wait state -> xfer_count=1, err_valid never asserted, busy high for 3 cycles.
REQ-029 Bench SHALL drive penable=1 with psel=0 in IDLE, paddr=0x0A4 -> err_valid pulse, err_code=1, err_addr=0x0A4, err_sticky=6'b000001.
REQ-030 Bench SHALL change paddr 0x020->0x024 during a wait state in ACCESS -> one err_code=3 pulse, transfer still completes, xfer_count=1.
REQ-031 Bench SHALL run with TIMEOUT=4 and hold pready=0 for 10 cycles -> a single err_code=6 pulse 4 cycles after ACCESS entry, err_count=1.
REQ-032 Bench SHALL raise err_clr in the same cycle as a MULTI_SEL (NSEL=2, psel=2'b11) after prior errors -> err_sticky=6'b001000, err_count=1.
REQ-033 Bench SHALL assert preset during ACCESS and release it -> all outputs zero, busy=0, and the next clean transfer counts as xfer_count=1.
